// File: rtl/regfile_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter_if
//   Valid/ready write-request channel into the register-file write arbiter.
//   One instance per requester (A = ALU writeback, B = load return).
//
//   Signals:
//     valid  requester has a write this cycle
//     ready  arbiter accepts the write when valid & ready
//     addr   destination register (ADDR_W bits)
//     data   write data (DATA_W bits)
//
//   Modports:
//     master  requester side (drives valid/addr/data, samples ready)
//     slave   arbiter side   (samples valid/addr/data, drives ready)
// ---------------------------------------------------------------------------
interface regfile_wr_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
//   Merges two write sources (A = ALU writeback, B = load return) onto the
//   single register-file write port. Each source owns a one-deep hold entry;
//   a 1-bit round-robin pointer picks between them when both are pending,
//   and the winner is registered onto regwrite/wraddr/wrdata.
//
//   Ports:
//     clk       single clock, rising edge
//     reset     synchronous, active-high
//     a         requester A channel (regfile_wr_arbiter_if.slave)
//     b         requester B channel (regfile_wr_arbiter_if.slave)
//     regwrite  register-file write enable
//     wraddr    register-file write address
//     wrdata    register-file write data
//     busy      any hold entry or the output register is valid
//
//   Build option:
//     WRARB_XZR_FILTER_EN  when defined, a granted entry whose address is
//                          all-ones (XZR) retires normally but does not
//                          raise regwrite.
// ---------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_wr_arbiter_if.slave   a,
    regfile_wr_arbiter_if.slave   b,
    output logic                  regwrite,
    output logic [ADDR_W-1:0]     wraddr,
    output logic [DATA_W-1:0]     wrdata,
    output logic                  busy
);

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

`ifdef WRARB_XZR_FILTER_EN
    function automatic logic is_xzr(input logic [ADDR_W-1:0] addr);
        return &addr;
    endfunction
`endif

    // Hold entries (stage p0)
    logic              a_vld_p0;
    logic [ADDR_W-1:0] a_addr_p0;
    logic [DATA_W-1:0] a_data_p0;
    logic              b_vld_p0;
    logic [ADDR_W-1:0] b_addr_p0;
    logic [DATA_W-1:0] b_data_p0;

    // Output register (stage p1)
    logic              vld_p1;
    logic [ADDR_W-1:0] wraddr_p1;
    logic [DATA_W-1:0] wrdata_p1;

    req_e              last_grant;

    logic              grant_a;
    logic              grant_b;
    logic              accept_a;
    logic              accept_b;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              issue_we;

    // Arbitration looks only at the hold entries, never at the live inputs,
    // so ready does not depend combinationally on valid.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_vld_p0 && b_vld_p0) begin
            if (last_grant == REQ_B) grant_a = 1'b1;
            else                     grant_b = 1'b1;
        end else if (a_vld_p0) begin
            grant_a = 1'b1;
        end else if (b_vld_p0) begin
            grant_b = 1'b1;
        end
    end

    // An entry being granted this cycle frees up at the edge, so it can be
    // refilled in the same cycle: this is what lets a lone requester stream.
    assign a.ready  = ~a_vld_p0 | grant_a;
    assign b.ready  = ~b_vld_p0 | grant_b;
    assign accept_a = a.valid & a.ready;
    assign accept_b = b.valid & b.ready;

    assign sel_addr = grant_a ? a_addr_p0 : b_addr_p0;
    assign sel_data = grant_a ? a_data_p0 : b_data_p0;

`ifdef WRARB_XZR_FILTER_EN
    assign issue_we = (grant_a | grant_b) & ~is_xzr(sel_addr);
`else
    assign issue_we = grant_a | grant_b;
`endif

    // p0: hold-entry control; a refill wins over the clear from a grant
    always_ff @(posedge clk) begin
        if (reset) begin
            a_vld_p0   <= 1'b0;
            b_vld_p0   <= 1'b0;
            last_grant <= REQ_B;
        end else begin
            if (accept_a)     a_vld_p0 <= 1'b1;
            else if (grant_a) a_vld_p0 <= 1'b0;
            if (accept_b)     b_vld_p0 <= 1'b1;
            else if (grant_b) b_vld_p0 <= 1'b0;
            if (grant_a)      last_grant <= REQ_A;
            else if (grant_b) last_grant <= REQ_B;
        end
    end

    // p0: hold-entry payload, captured only on accept
    always_ff @(posedge clk) begin
        if (accept_a) begin
            a_addr_p0 <= a.addr;
            a_data_p0 <= a.data;
        end
        if (accept_b) begin
            b_addr_p0 <= b.addr;
            b_data_p0 <= b.data;
        end
    end

    // p1: output register; address/data hold their last value between grants
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            wraddr_p1 <= '0;
            wrdata_p1 <= '0;
        end else begin
            vld_p1 <= issue_we;
            if (grant_a || grant_b) begin
                wraddr_p1 <= sel_addr;
                wrdata_p1 <= sel_data;
            end
        end
    end

    assign regwrite = vld_p1;
    assign wraddr   = wraddr_p1;
    assign wrdata   = wrdata_p1;
    assign busy     = a_vld_p0 | b_vld_p0 | vld_p1;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//   Self-checking bench for regfile_wr_arbiter. A queue-based reference model
//   tracks pending writes per requester and the expected write stream; the
//   DUT is compared against it every cycle, with directed scenarios followed
//   by randomized traffic. Honours WRARB_XZR_FILTER_EN like the design.
// ---------------------------------------------------------------------------
module tb_regfile_wr_arbiter;
    localparam int AW = 5;
    localparam int DW = 64;
`ifdef WRARB_XZR_FILTER_EN
    localparam bit XZR_EN = 1'b1;
`else
    localparam bit XZR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          regwrite;
    logic [AW-1:0] wraddr;
    logic [DW-1:0] wrdata;
    logic          busy;

    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
    regfile_wr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();

    regfile_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a_if),
        .b        (b_if),
        .regwrite (regwrite),
        .wraddr   (wraddr),
        .wrdata   (wrdata),
        .busy     (busy)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    // Reference model: pending writes per requester, who won last, and
    // what the write port must show in the current cycle.
    wr_t           mq_a[$];
    wr_t           mq_b[$];
    bit            m_last_b;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    wr_t           dut_log[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit filtered(input logic [AW-1:0] ad);
        return XZR_EN && (ad == {AW{1'b1}});
    endfunction

    function automatic bit m_grant_a();
        return (mq_a.size() != 0) && ((mq_b.size() == 0) || m_last_b);
    endfunction

    function automatic bit m_grant_b();
        return (mq_b.size() != 0) && !m_grant_a();
    endfunction

    function automatic bit m_rdy_a();
        return (mq_a.size() == 0) || m_grant_a();
    endfunction

    function automatic bit m_rdy_b();
        return (mq_b.size() == 0) || m_grant_b();
    endfunction

    task automatic model_reset();
        mq_a.delete();
        mq_b.delete();
        m_last_b = 1'b1;
        m_we     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endtask

    // One clock cycle: check this cycle's outputs, drive inputs, advance the
    // model across the coming edge, then wait for the next falling edge.
    task automatic step(input bit rs,
                        input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        bit  ga, gb, ra, rb;
        wr_t w;
        ga = m_grant_a();
        gb = m_grant_b();
        ra = m_rdy_a();
        rb = m_rdy_b();
        check_eq("a_ready",  DW'(a_if.ready), DW'(ra));
        check_eq("b_ready",  DW'(b_if.ready), DW'(rb));
        check_eq("regwrite", DW'(regwrite),   DW'(m_we));
        check_eq("wraddr",   DW'(wraddr),     DW'(m_addr));
        check_eq("wrdata",   wrdata,          m_data);
        check_eq("busy",     DW'(busy), DW'((mq_a.size() != 0) || (mq_b.size() != 0) || m_we));
        if (regwrite === 1'b1) dut_log.push_back({wraddr, wrdata});

        reset      = rs;
        a_if.valid = av;
        a_if.addr  = aa;
        a_if.data  = ad;
        b_if.valid = bv;
        b_if.addr  = ba;
        b_if.data  = bd;

        if (rs) begin
            model_reset();
        end else begin
            m_we = 1'b0;
            if (ga) begin
                w = mq_a.pop_front();
                m_we = !filtered(w.addr);
                m_addr = w.addr;
                m_data = w.data;
                m_last_b = 1'b0;
            end else if (gb) begin
                w = mq_b.pop_front();
                m_we = !filtered(w.addr);
                m_addr = w.addr;
                m_data = w.data;
                m_last_b = 1'b1;
            end
            if (av && ra) mq_a.push_back({aa, ad});
            if (bv && rb) mq_b.push_back({ba, bd});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        int ia, ib, base;
        bit acc_a, acc_b;
        wr_t e;

        reset      = 1'b1;
        a_if.valid = 1'b0;
        a_if.addr  = '0;
        a_if.data  = '0;
        b_if.valid = 1'b0;
        b_if.addr  = '0;
        b_if.data  = '0;
        repeat (3) @(negedge clk);
        model_reset();
        do_reset();

        // Single A write: visible two cycles after acceptance, then drops.
        step(1'b0, 1'b1, 5'd3, 64'h11, 1'b0, '0, '0);
        idle();
        check_eq("a_only_we",   DW'(regwrite), 64'd1);
        check_eq("a_only_addr", DW'(wraddr),   64'd3);
        check_eq("a_only_data", wrdata,        64'h11);
        idle();
        check_eq("a_only_we_off", DW'(regwrite), 64'd0);
        idle();

        // Simultaneous A/B after reset: A first, B stalls one cycle.
        do_reset();
        step(1'b0, 1'b1, 5'd5, 64'hAA, 1'b1, 5'd6, 64'hBB);
        check_eq("conflict_b_ready", DW'(b_if.ready), 64'd0);
        check_eq("conflict_a_ready", DW'(a_if.ready), 64'd1);
        idle();
        check_eq("conflict_w1_addr", DW'(wraddr), 64'd5);
        check_eq("conflict_w1_data", wrdata,      64'hAA);
        idle();
        check_eq("conflict_w2_we",   DW'(regwrite), 64'd1);
        check_eq("conflict_w2_addr", DW'(wraddr),   64'd6);
        check_eq("conflict_w2_data", wrdata,        64'hBB);
        idle();

        // Same destination from both: two writes, B's value lands last.
        do_reset();
        step(1'b0, 1'b1, 5'd7, 64'h1, 1'b1, 5'd7, 64'h2);
        idle();
        check_eq("same_addr_w1", wrdata, 64'h1);
        idle();
        check_eq("same_addr_w2_we",   DW'(regwrite), 64'd1);
        check_eq("same_addr_w2_addr", DW'(wraddr),   64'd7);
        check_eq("same_addr_w2_data", wrdata,        64'h2);
        idle();

        // Reset with both holds full discards everything.
        step(1'b0, 1'b1, 5'd1, 64'h101, 1'b1, 5'd2, 64'h202);
        step(1'b0, 1'b1, 5'd3, 64'h303, 1'b1, 5'd4, 64'h404);
        step(1'b1, 1'b1, 5'd8, 64'h808, 1'b1, 5'd9, 64'h909);
        check_eq("rst_full_we",     DW'(regwrite),   64'd0);
        check_eq("rst_full_busy",   DW'(busy),       64'd0);
        check_eq("rst_full_a_rdy",  DW'(a_if.ready), 64'd1);
        check_eq("rst_full_b_rdy",  DW'(b_if.ready), 64'd1);
        idle();

        // Write to the all-ones register.
        do_reset();
        step(1'b0, 1'b1, 5'd31, 64'h5A, 1'b0, '0, '0);
        idle();
        check_eq("xzr_we",    DW'(regwrite),   XZR_EN ? 64'd0 : 64'd1);
        check_eq("xzr_addr",  DW'(wraddr),     64'd31);
        check_eq("xzr_a_rdy", DW'(a_if.ready), 64'd1);
        idle();

        // Both requesters streaming 8 writes each: strict alternation A,B,...
        do_reset();
        base = dut_log.size();
        ia = 0;
        ib = 0;
        for (int c = 0; c < 60 && (ia < 8 || ib < 8); c++) begin
            acc_a = (ia < 8) && m_rdy_a();
            acc_b = (ib < 8) && m_rdy_b();
            step(1'b0, ia < 8, AW'(ia), 64'hA000 + 64'(ia),
                       ib < 8, AW'(ib + 16), 64'hB000 + 64'(ib));
            if (acc_a) ia++;
            if (acc_b) ib++;
        end
        check_eq("stream_accepts", 64'(ia + ib), 64'd16);
        repeat (4) idle();
        check_eq("stream_writes", 64'(dut_log.size() - base), 64'd16);
        for (int k = 0; k < 16 && (base + k) < dut_log.size(); k++) begin
            e = dut_log[base + k];
            check_eq("stream_order", e.data, (k % 2 == 0) ? 64'hA000 + 64'(k / 2) : 64'hB000 + 64'(k / 2));
        end

        // Randomized traffic with occasional all-ones addresses and resets.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [AW-1:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? {AW{1'b1}} : AW'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? {AW{1'b1}} : AW'($urandom);
            step($urandom_range(0, 63) == 0,
                 1'($urandom), ra, {$urandom, $urandom},
                 1'($urandom), rb, {$urandom, $urandom});
        end
        repeat (4) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus loop ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
